instruction_fetch: RTL and testbench
====================================

# instruction_fetch

Fetch unit that supplies 16-bit instruction words to the datapath's instruction register. Holds the 10-bit program counter and runs a request/acknowledge read handshake against instruction memory. Delivers each fetched word together with a one-cycle `irw` write strobe, and handles taken branches, including discarding a fetch that is in flight. Sits between instruction memory and the instruction register, under control-unit `stall`.

## Interface
- `ADDR_W`, 10, program counter and memory address width (word addressed)
- `INSTR_W`, 16, instruction word width
- `RESET_PC`, 0, program counter value after reset

- `CLK`  in  1  single clock, all state updates on rising edge
- `reset`  in  1  asynchronous, active-high; clears all state immediately
- `stall`  in  1  control unit: do not issue a new fetch while high
- `branch_taken`  in  1  single-cycle redirect pulse
- `branch_target`  in  ADDR_W  redirect address, valid with `branch_taken`
- `imem_req`  out  1  read request, held high until acknowledged
- `imem_addr`  out  ADDR_W  read address, stable while `imem_req` is high
- `imem_ack`  in  1  memory has `imem_rdata` valid this cycle
- `imem_rdata`  in  INSTR_W  read data
- `instr`  out  INSTR_W  last delivered instruction word
- `irw`  out  1  instruction register write strobe, one cycle per delivered word
- `pc`  out  ADDR_W  current program counter (address of the next fetch)

## Operation
- Reset values:
  - `pc`=RESET_PC, `imem_req`=0, `imem_addr`=0, `instr`=0, `irw`=0.
  - state IDLE, `squash`=0.
- States: IDLE (no request outstanding), WAIT (request outstanding).
- IDLE, `stall`=0:
  - latch `imem_addr` = (`branch_taken` ? `branch_target` : `pc`).
  - if `branch_taken`, `pc` <= `branch_target`.
  - `imem_req` <= 1; go to WAIT.
- IDLE, `stall`=1: hold. `branch_taken` still loads `pc` <= `branch_target`.
- WAIT, `imem_ack`=0:
  - hold `imem_req` and `imem_addr`.
  - `branch_taken` loads `pc` <= `branch_target` and sets `squash`=1.
- WAIT, `imem_ack`=1, `squash`=0 and `branch_taken`=0:
  - `instr` <= `imem_rdata`, `irw` <= 1.
  - `pc` <= `pc`+1, modulo 2^ADDR_W (1023 wraps to 0).
  - `imem_req` <= 0; go to IDLE.
- WAIT, `imem_ack`=1 with `squash`=1 or `branch_taken`=1:
  - data discarded; `instr` unchanged, no `irw`.
  - `pc` <= `branch_target` if `branch_taken`, else unchanged.
  - clear `squash`; go to IDLE.
- `irw` deasserts the cycle after it rises; it never stays high two cycles.
- `stall` does not abort an outstanding request. That request completes and its word is delivered.
- `imem_ack` while in IDLE is ignored.
- `reset` during WAIT:
  - drops `imem_req` asynchronously.
  - a late `imem_ack` after reset lands in IDLE and is ignored.

## Timing
- Registered outputs only; no combinational path from any input to any output.
- Issue latency: IDLE with `stall`=0 at edge N gives `imem_req`=1 in cycle N+1.
- Delivery latency: `imem_ack` sampled at edge M gives `instr` valid and `irw`=1 in cycle M+1.
- Throughput with zero-wait memory (ack in first request cycle): one instruction per 2 cycles.
- Memory may hold off `imem_ack` indefinitely; the block waits with no timeout.
- A redirect seen in any cycle is reflected in `pc` the next cycle.

## Structure
- Package `fetch_pkg` holds:
  - state enum `fetch_state_t` {IDLE, WAIT}
  - width constants matching ADDR_W/INSTR_W defaults
  - `RESET_PC` default
- Single module; no sub-module needed. The PC increment/redirect mux stays inline.

## Test plan
- Reset, `stall`=0, memory acks the first request cycle returning 16'h1234 → `imem_addr`=0, `instr`=16'h1234 with a one-cycle `irw`, `pc`=1; next request issues at addr 1 two cycles after the first.
- Memory with 3 wait cycles → `imem_req` and `imem_addr` stable for 4 cycles; exactly one `irw`.
- `branch_taken` with target 10'h080 during WAIT, ack two cycles later with 16'hDEAD → no `irw`, `instr` unchanged, next `imem_addr`=10'h080.
- `branch_taken` with target 10'h010 in the same cycle as `imem_ack` → data dropped, `pc`=10'h010.
- `pc` at 10'h3FF fetch completes → `pc`=0, next `imem_addr`=0.
- `stall` raised during WAIT → word still delivered with `irw`, then no new `imem_req` until `stall`=0.
- `reset` asserted mid-WAIT → `imem_req`=0 immediately, `pc`=RESET_PC; a subsequent stray `imem_ack` produces no `irw`.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and default widths for the instruction fetch unit.
package fetch_pkg;

  localparam int FETCH_ADDR_W  = 10;
  localparam int FETCH_INSTR_W = 16;
  localparam logic [FETCH_ADDR_W-1:0] FETCH_RESET_PC = 10'd0;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/instruction_fetch.sv
// Fetch unit: owns the PC, runs the req/ack read handshake with instruction memory
// and delivers each word with a one-cycle irw strobe; branches can squash a fetch in flight.
module instruction_fetch
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = FETCH_ADDR_W,
  parameter int                INSTR_W  = FETCH_INSTR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = FETCH_RESET_PC
) (
  input  logic               CLK,
  input  logic               reset,
  input  logic               stall,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_target,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instr,
  output logic               irw,
  output logic [ADDR_W-1:0]  pc
);

  fetch_state_t        r_state;
  logic [ADDR_W-1:0]   r_pc;
  logic                r_req;
  logic [ADDR_W-1:0]   r_addr;
  logic [INSTR_W-1:0]  r_instr;
  logic                r_irw;
  logic                r_squash;

  fetch_state_t        w_state_nxt;
  logic [ADDR_W-1:0]   w_pc_nxt;
  logic                w_req_nxt;
  logic [ADDR_W-1:0]   w_addr_nxt;
  logic [INSTR_W-1:0]  w_instr_nxt;
  logic                w_irw_nxt;
  logic                w_squash_nxt;

  // State and output registers; reset also drops an outstanding request at once.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_pc     <= RESET_PC;
      r_req    <= 1'b0;
      r_addr   <= '0;
      r_instr  <= '0;
      r_irw    <= 1'b0;
      r_squash <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_pc     <= w_pc_nxt;
      r_req    <= w_req_nxt;
      r_addr   <= w_addr_nxt;
      r_instr  <= w_instr_nxt;
      r_irw    <= w_irw_nxt;
      r_squash <= w_squash_nxt;
    end
  end

  // Next-state logic; a branch always wins over the sequential PC increment.
  always_comb begin
    w_state_nxt  = r_state;
    w_pc_nxt     = r_pc;
    w_req_nxt    = r_req;
    w_addr_nxt   = r_addr;
    w_instr_nxt  = r_instr;
    w_irw_nxt    = 1'b0;
    w_squash_nxt = r_squash;
    case (r_state)
      IDLE: begin
        if (branch_taken) begin
          w_pc_nxt = branch_target;
        end else begin
          w_pc_nxt = r_pc;
        end
        if (!stall) begin
          w_addr_nxt  = branch_taken ? branch_target : r_pc;
          w_req_nxt   = 1'b1;
          w_state_nxt = WAIT;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      WAIT: begin
        if (!imem_ack) begin
          if (branch_taken) begin
            w_pc_nxt     = branch_target;
            w_squash_nxt = 1'b1;
          end else begin
            w_pc_nxt = r_pc;
          end
        end else if (r_squash || branch_taken) begin
          // Word belongs to the abandoned path: drop it.
          w_pc_nxt     = branch_taken ? branch_target : r_pc;
          w_squash_nxt = 1'b0;
          w_req_nxt    = 1'b0;
          w_state_nxt  = IDLE;
        end else begin
          w_instr_nxt = imem_rdata;
          w_irw_nxt   = 1'b1;
          w_pc_nxt    = r_pc + ADDR_W'(1);
          w_req_nxt   = 1'b0;
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt  = IDLE;
        w_req_nxt    = 1'b0;
        w_squash_nxt = 1'b0;
      end
    endcase
  end

  assign imem_req  = r_req;
  assign imem_addr = r_addr;
  assign instr     = r_instr;
  assign irw       = r_irw;
  assign pc        = r_pc;

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch: delivered words are queued when acked
// and popped by a monitor whenever irw strobes.
module tb_instruction_fetch;
  import fetch_pkg::*;

  logic        CLK = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [9:0]  branch_target = 10'd0;
  logic        imem_req;
  logic [9:0]  imem_addr;
  logic        imem_ack = 1'b0;
  logic [15:0] imem_rdata = 16'h0000;
  logic [15:0] instr;
  logic        irw;
  logic [9:0]  pc;

  int n_checks = 0;
  int n_pass   = 0;
  int n_irw    = 0;
  int n_push   = 0;
  logic [15:0] exp_q[$];
  logic prev_irw = 1'b0;

  instruction_fetch dut (
    .CLK(CLK), .reset(reset), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr(instr), .irw(irw), .pc(pc)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_req();
    int n = 0;
    while (!imem_req && n < 20) begin
      step();
      n++;
    end
    chk("req_timeout", {31'd0, imem_req}, 32'd1);
  endtask

  task automatic push_word(input logic [15:0] d);
    exp_q.push_back(d);
    n_push++;
  endtask

  task automatic do_fetch(input int waits, input logic [15:0] data,
                          input logic [9:0] exp_addr, input logic [9:0] exp_pc);
    wait_req();
    chk("fetch_addr", {22'd0, imem_addr}, {22'd0, exp_addr});
    for (int i = 0; i < waits; i++) begin
      step();
      chk("req_hold", {31'd0, imem_req}, 32'd1);
      chk("addr_hold", {22'd0, imem_addr}, {22'd0, exp_addr});
    end
    imem_ack = 1'b1;
    imem_rdata = data;
    push_word(data);
    step();
    imem_ack = 1'b0;
    imem_rdata = 16'h0000;
    chk("pc_after", {22'd0, pc}, {22'd0, exp_pc});
    chk("req_drop", {31'd0, imem_req}, 32'd0);
  endtask

  // Scoreboard monitor: every irw pulse must match the oldest expected word.
  always @(negedge CLK) begin
    if (irw) begin
      n_irw++;
      chk("irw_pulse", {31'd0, prev_irw}, 32'd0);
      if (exp_q.size() > 0) begin
        chk("instr", {16'd0, instr}, {16'd0, exp_q.pop_front()});
      end else begin
        chk("irw_unexpected", {31'd0, irw}, 32'd0);
      end
    end
    prev_irw = irw;
  end

  initial begin
    int irw_before;
    // reset values
    step(); step();
    chk("rst_pc", {22'd0, pc}, 32'd0);
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_addr", {22'd0, imem_addr}, 32'd0);
    chk("rst_instr", {16'd0, instr}, 32'd0);
    chk("rst_irw", {31'd0, irw}, 32'd0);
    reset = 1'b0;

    // zero-wait fetch, next request two cycles after the first
    do_fetch(0, 16'h1234, 10'h000, 10'h001);
    step();
    chk("next_req", {31'd0, imem_req}, 32'd1);
    chk("next_addr", {22'd0, imem_addr}, 32'd1);

    // three wait cycles, exactly one irw
    irw_before = n_irw;
    do_fetch(3, 16'hABCD, 10'h001, 10'h002);
    step();
    chk("one_irw", n_irw - irw_before, 32'd1);

    // branch during WAIT squashes the late data
    wait_req();
    chk("br_addr", {22'd0, imem_addr}, 32'h002);
    branch_taken = 1'b1; branch_target = 10'h080;
    step();
    branch_taken = 1'b0;
    chk("br_pc", {22'd0, pc}, 32'h080);
    chk("br_addr_hold", {22'd0, imem_addr}, 32'h002);
    step();
    imem_ack = 1'b1; imem_rdata = 16'hDEAD;
    step();
    imem_ack = 1'b0;
    chk("sq_irw", {31'd0, irw}, 32'd0);
    chk("sq_instr", {16'd0, instr}, 32'hABCD);
    step();
    chk("sq_next_req", {31'd0, imem_req}, 32'd1);
    chk("sq_next_addr", {22'd0, imem_addr}, 32'h080);

    // branch coincident with ack
    imem_ack = 1'b1; imem_rdata = 16'hBEEF;
    branch_taken = 1'b1; branch_target = 10'h010;
    step();
    imem_ack = 1'b0; branch_taken = 1'b0;
    chk("coinc_pc", {22'd0, pc}, 32'h010);
    chk("coinc_irw", {31'd0, irw}, 32'd0);
    chk("coinc_instr", {16'd0, instr}, 32'hABCD);
    step();
    chk("coinc_addr", {22'd0, imem_addr}, 32'h010);

    // PC wrap from 0x3FF
    imem_ack = 1'b1; imem_rdata = 16'h1111;
    branch_taken = 1'b1; branch_target = 10'h3FF;
    step();
    imem_ack = 1'b0; branch_taken = 1'b0;
    chk("wrap_setup_pc", {22'd0, pc}, 32'h3FF);
    do_fetch(0, 16'h5A5A, 10'h3FF, 10'h000);
    do_fetch(1, 16'h0F0F, 10'h000, 10'h001);

    // stall during WAIT: word still delivered, then no new request
    wait_req();
    chk("stall_addr", {22'd0, imem_addr}, 32'h001);
    stall = 1'b1;
    step();
    chk("stall_req_hold", {31'd0, imem_req}, 32'd1);
    imem_ack = 1'b1; imem_rdata = 16'h7777;
    push_word(16'h7777);
    step();
    imem_ack = 1'b0;
    chk("stall_pc", {22'd0, pc}, 32'h002);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_no_req", {31'd0, imem_req}, 32'd0);
    end
    branch_taken = 1'b1; branch_target = 10'h100;
    step();
    branch_taken = 1'b0;
    chk("stall_br_pc", {22'd0, pc}, 32'h100);
    chk("stall_br_req", {31'd0, imem_req}, 32'd0);
    stall = 1'b0;
    step();
    chk("unstall_req", {31'd0, imem_req}, 32'd1);
    chk("unstall_addr", {22'd0, imem_addr}, 32'h100);

    // reset mid-WAIT, then a stray ack
    step();
    stall = 1'b1;
    reset = 1'b1;
    #1;
    chk("arst_req", {31'd0, imem_req}, 32'd0);
    chk("arst_pc", {22'd0, pc}, 32'd0);
    step();
    reset = 1'b0;
    imem_ack = 1'b1; imem_rdata = 16'hEEEE;
    step();
    imem_ack = 1'b0;
    chk("stray_irw", {31'd0, irw}, 32'd0);
    chk("stray_req", {31'd0, imem_req}, 32'd0);
    chk("stray_instr", {16'd0, instr}, 32'd0);
    step();
    chk("irw_count", n_irw, n_push);
    chk("queue_empty", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
